// File: rtl/load_ab_pingpong_if.sv
// load_ab_pingpong_if: stream and MAC-side signals of one A/B loader PE.
// master drives the loader inputs, slave is the loader itself.
interface load_ab_pingpong_if #(
  parameter int D_WIDTH     = 64,
  parameter int B_NUM_WIDTH = 8
);
  logic [B_NUM_WIDTH-1:0] cfg_b_num;

  logic [D_WIDTH-1:0]     a_in_data;
  logic                   a_in_valid;
  logic                   a_in_ready;
  logic [D_WIDTH-1:0]     a_pass_data;
  logic                   a_pass_valid;
  logic                   a_pass_ready;

  logic [D_WIDTH-1:0]     b_in_data;
  logic                   b_in_valid;
  logic                   b_in_ready;
  logic [D_WIDTH-1:0]     b_pass_data;
  logic                   b_pass_valid;
  logic                   b_pass_ready;

  logic [D_WIDTH-1:0]     out_a;
  logic [D_WIDTH-1:0]     out_b;
  logic                   out_valid;
  logic                   out_ready;
  logic                   tile_done;

  modport master (
    output cfg_b_num,
    output a_in_data, a_in_valid,
    input  a_in_ready,
    input  a_pass_data, a_pass_valid,
    output a_pass_ready,
    output b_in_data, b_in_valid,
    input  b_in_ready,
    input  b_pass_data, b_pass_valid,
    output b_pass_ready,
    input  out_a, out_b, out_valid,
    output out_ready,
    input  tile_done
  );

  modport slave (
    input  cfg_b_num,
    input  a_in_data, a_in_valid,
    output a_in_ready,
    output a_pass_data, a_pass_valid,
    input  a_pass_ready,
    input  b_in_data, b_in_valid,
    output b_in_ready,
    output b_pass_data, b_pass_valid,
    input  b_pass_ready,
    output out_a, out_b, out_valid,
    input  out_ready,
    output tile_done
  );
endinterface

// File: rtl/load_ab_pingpong.sv
// load_ab_pingpong: per-PE A/B operand loader for the systolic array.
// Ping-pong A banks, forwarded A/B chains, PE_NUM MAC pairs per B word.
module load_ab_pingpong #(
  parameter int D_WIDTH      = 64,
  parameter int PE_NUM       = 4,
  parameter int PE_NUM_WIDTH = 2,
  parameter int PE_CNT       = 2,
  parameter int A_CNT_WIDTH  = 3,
  parameter int PID          = 0,
  parameter int B_NUM_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  load_ab_pingpong_if.slave io
);
  localparam int A_LO = PID * PE_NUM;
  localparam int A_HI = A_LO + PE_NUM;
  localparam logic [A_CNT_WIDTH-1:0] A_LAST =
    A_CNT_WIDTH'(PE_CNT * PE_NUM - 1);
  localparam logic [PE_NUM_WIDTH-1:0] K_LAST =
    PE_NUM_WIDTH'(PE_NUM - 1);
  localparam logic [PE_NUM_WIDTH-1:0] K_ONE =
    PE_NUM_WIDTH'(1);

  typedef enum logic {
    L_FILL,
    L_FULL
  } lstate_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT_B,
    C_EMIT
  } cstate_t;

  lstate_t lstate;
  cstate_t cstate;

  logic [A_CNT_WIDTH-1:0]  a_cnt;
  logic                    load_sel;
  logic                    comp_sel;
  logic [1:0]              bank_v;
  logic [B_NUM_WIDTH-1:0]  b_tgt;
  logic [B_NUM_WIDTH-1:0]  b_cnt;
  logic [PE_NUM_WIDTH-1:0] k;
  logic [PE_NUM_WIDTH-1:0] rk;
  logic                    iss_done;
  logic [D_WIDTH-1:0]      b_hold;

  logic [D_WIDTH-1:0]      a_pd;
  logic                    a_pv;
  logic [D_WIDTH-1:0]      b_pd;
  logic                    b_pv;

  logic [D_WIDTH-1:0]      mem [2*PE_NUM];
  logic [D_WIDTH-1:0]      rd_data;
  logic                    rd_vld;

  logic [D_WIDTH-1:0]      out_a_q;
  logic [D_WIDTH-1:0]      out_b_q;
  logic                    out_vld_q;
  logic                    tile_done_q;

  logic                    a_in_ready;
  logic                    a_acc;
  logic                    in_slice;
  logic                    wr_en;
  logic [PE_NUM_WIDTH-1:0] wr_k;
  logic [PE_NUM_WIDTH:0]   wr_addr;
  logic                    swap;
  logic                    pair_acc;
  logic                    last_pair;
  logic                    b_last;
  logic                    rel;
  logic                    b_slot;
  logic                    b_in_ready;
  logic                    b_acc;
  logic                    out_load;
  logic                    rd_en;
  logic [PE_NUM_WIDTH-1:0] rd_k;
  logic [PE_NUM_WIDTH:0]   rd_addr;

  always_comb begin
    a_in_ready = rst_n
              && (lstate == L_FILL)
              && !bank_v[load_sel]
              && (!a_pv || io.a_pass_ready);
    a_acc    = io.a_in_valid && a_in_ready;
    in_slice = (int'(a_cnt) >= A_LO)
            && (int'(a_cnt) < A_HI);
    wr_en    = a_acc && in_slice;
    wr_k     = PE_NUM_WIDTH'(int'(a_cnt) - A_LO);
    wr_addr  = {load_sel, wr_k};
    swap     = (lstate == L_FULL) && (cstate == C_IDLE);
  end

  // The next B may enter in the same cycle the last pair leaves.
  always_comb begin
    pair_acc  = out_vld_q && io.out_ready;
    last_pair = (cstate == C_EMIT) && pair_acc
             && (k == K_LAST);
    b_last    = (b_cnt + 1'b1) == b_tgt;
    rel       = last_pair && b_last;
    b_slot    = (cstate == C_WAIT_B)
             || (last_pair && !b_last);
    b_in_ready = rst_n && b_slot
              && (!b_pv || io.b_pass_ready);
    b_acc     = io.b_in_valid && b_in_ready;
  end

  always_comb begin
    out_load = rd_vld && (!out_vld_q || io.out_ready);
    rd_en    = b_acc
            || ((cstate == C_EMIT) && !iss_done
                && (!rd_vld || out_load));
    rd_k     = b_acc ? '0 : rk;
    rd_addr  = {comp_sel, rd_k};
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= io.a_in_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_pd <= '0;
      a_pv <= 1'b0;
      b_pd <= '0;
      b_pv <= 1'b0;
    end else begin
      if (a_acc) begin
        a_pd <= io.a_in_data;
        a_pv <= 1'b1;
      end else if (io.a_pass_ready) begin
        a_pv <= 1'b0;
      end
      if (b_acc) begin
        b_pd <= io.b_in_data;
        b_pv <= 1'b1;
      end else if (io.b_pass_ready) begin
        b_pv <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lstate   <= L_FILL;
      a_cnt    <= '0;
      load_sel <= 1'b0;
      bank_v   <= '0;
    end else begin
      if (rel) bank_v[comp_sel] <= 1'b0;
      unique case (lstate)
        L_FILL: begin
          if (a_acc) begin
            if (a_cnt == A_LAST) begin
              a_cnt            <= '0;
              bank_v[load_sel] <= 1'b1;
              lstate           <= L_FULL;
            end else begin
              a_cnt <= a_cnt + 1'b1;
            end
          end
        end
        L_FULL: begin
          if (swap) begin
            load_sel <= ~load_sel;
            lstate   <= L_FILL;
          end
        end
        default: lstate <= L_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cstate      <= C_IDLE;
      comp_sel    <= 1'b0;
      b_tgt       <= '0;
      b_cnt       <= '0;
      k           <= '0;
      rk          <= '0;
      iss_done    <= 1'b1;
      b_hold      <= '0;
      rd_vld      <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_vld_q   <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      if (b_acc) begin
        b_hold   <= io.b_in_data;
        rk       <= K_ONE;
        iss_done <= (PE_NUM == 1);
      end else if (rd_en) begin
        rk       <= rk + 1'b1;
        iss_done <= (rk == K_LAST);
      end
      if (rd_en) rd_vld <= 1'b1;
      else if (out_load) rd_vld <= 1'b0;
      if (out_load) begin
        out_a_q   <= rd_data;
        out_b_q   <= b_hold;
        out_vld_q <= 1'b1;
      end else if (io.out_ready) begin
        out_vld_q <= 1'b0;
      end
      unique case (cstate)
        C_IDLE: begin
          if (swap) begin
            comp_sel <= load_sel;
            b_tgt    <= io.cfg_b_num;
            cstate   <= C_WAIT_B;
          end
        end
        C_WAIT_B: begin
          if (b_acc) cstate <= C_EMIT;
        end
        C_EMIT: begin
          if (pair_acc) begin
            k <= k + 1'b1;
            if (k == K_LAST) begin
              if (b_last) begin
                b_cnt       <= '0;
                tile_done_q <= 1'b1;
                cstate      <= C_IDLE;
              end else begin
                b_cnt  <= b_cnt + 1'b1;
                cstate <= b_acc ? C_EMIT : C_WAIT_B;
              end
            end
          end
        end
        default: cstate <= C_IDLE;
      endcase
    end
  end

  assign io.a_in_ready   = a_in_ready;
  assign io.a_pass_data  = a_pd;
  assign io.a_pass_valid = a_pv;
  assign io.b_in_ready   = b_in_ready;
  assign io.b_pass_data  = b_pd;
  assign io.b_pass_valid = b_pv;
  assign io.out_a        = out_a_q;
  assign io.out_b        = out_b_q;
  assign io.out_valid    = out_vld_q;
  assign io.tile_done    = tile_done_q;

endmodule
